aes256_cipher_core: RTL and testbench
=====================================

# aes256_cipher_core

Iterative AES-256 encryption datapath that sits directly downstream of `keyExpansion`. It drives `keyExpansion` one round per cycle and consumes the 128-bit round key that block returns. Each plaintext block takes 15 round cycles: an initial AddRoundKey, 13 full rounds and a final round without MixColumns. Input and output use valid/ready handshakes, and one block is in flight at a time.

## Interface
- No parameters; widths fixed by AES-256.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: plaintext/key offer.
- `in_ready` output 1: block can accept a new plaintext/key pair.
- `plaintext` input 128: bits [127:120] are state byte 0, in FIPS-197 column-major order.
- `key` input 256: cipher key; bits [255:248] are key byte 0.
- `out_valid` output 1: ciphertext is valid.
- `out_ready` input 1: downstream accepts the ciphertext.
- `ciphertext` output 128: same byte order as `plaintext`.
- `ke_key` output 256: to `keyExpansion` `key_in`; the registered copy of `key`.
- `ke_round_num` output 4: to `keyExpansion` `round_num`.
- `ke_enable_round` output 1: to `keyExpansion` `enable_round`.
- `ke_round_key` input 128: from `keyExpansion` `round_key_out`; round key for the current `ke_round_num`, combinational.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, register `plaintext` into `pt_reg` and `key` into `key_reg`, clear `rnd`, then go to ROUND.
- ROUND:
  - `ke_enable_round`=1 and `ke_round_num`=`rnd`.
  - `rnd`=0: state <= `pt_reg` ^ `ke_round_key`.
  - `rnd`=1..13: state <= MixColumns(ShiftRows(SubBytes(state))) ^ `ke_round_key`.
  - `rnd`=14: state <= ShiftRows(SubBytes(state)) ^ `ke_round_key`, then go to DONE.
  - `rnd` increments every ROUND cycle.
- DONE:
  - `out_valid`=1 and `ciphertext`=state.
  - On `out_ready`, go to IDLE.
- SubBytes uses 16 instances of the existing `sbox` module (ports `a`, `c`).
- MixColumns uses xtime over GF(2^8) with reduction polynomial 0x11B; all arithmetic is 8-bit XOR.
- `ke_key` is driven from `key_reg` at all times, so it is stable while `keyExpansion` samples it at `ke_round_num`=0.
- Outside ROUND: `ke_enable_round`=0 and `ke_round_num`=0.
- `in_ready`=0 in ROUND and DONE, so `in_valid` is ignored while busy. Inputs are sampled only at the accept edge.
- `ciphertext` holds its value until the next block completes.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=1, `out_valid`=0, `ciphertext`=0.
  - `ke_enable_round`=0, `ke_round_num`=0, `ke_key`=0.
  - `rnd`=0 and `pt_reg`=0.
- Latency:
  - Accept edge E0.
  - ROUND occupies the cycles between E0 and E15.
  - `out_valid` rises after E15, i.e. 15 cycles after accept.
- Throughput: 17 cycles per block when `out_ready` is held high. In the default build there is one IDLE cycle between blocks.
- Output handshake:
  - `out_valid` stays high and `ciphertext` stays stable until `out_ready` is sampled high.
  - Backpressure of any length is tolerated.
- Reset asserted mid-operation:
  - Every register returns to its reset value immediately.
  - The partial result is discarded and no `out_valid` is produced.
- `ke_round_num` never exceeds 14.

## Configuration
- `AES_CIPHER_BACKTOBACK_EN` defined:
  - In DONE, `in_ready`=`out_ready`.
  - If `out_ready`&`in_valid` are high together, the output is retired and the new block is accepted on the same edge, going straight to ROUND with `rnd`=0.
  - Throughput becomes 16 cycles per block.
- `AES_CIPHER_BACKTOBACK_EN` undefined: `in_ready`=0 in DONE, and the block always passes through IDLE.

## Test plan
- FIPS-197 C.3 vector:
  - Stimulus: `key`=000102…1e1f, `plaintext`=00112233445566778899aabbccddeeff, with `out_ready`=1.
  - Response: `ciphertext`=8ea2b7ca516745bfeafc49904b496089 with `out_valid` rising exactly 15 cycles after accept.
- All-zero vector:
  - Stimulus: `key`=0, `plaintext`=0.
  - Response: `ciphertext`=dc95c078a2408989ad48a21492842087.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid`, and toggle `in_valid` with a different plaintext meanwhile.
  - Response: `ciphertext` stays stable, `in_ready`=0, and the extra offer is not accepted.
- Reset mid-block:
  - Stimulus: drive `reset` low at `rnd`=7.
  - Response: all outputs return to reset values the same cycle.
  - Follow-up: a fresh C.3 block after reset still yields 8ea2b7ca….
- Back-to-back with `AES_CIPHER_BACKTOBACK_EN`:
  - Stimulus: two C.3 blocks with `in_valid`=`out_ready`=1.
  - Response: second `out_valid` occurs 16 cycles after the first.
  - Without the macro the spacing is 17 cycles.
- Key-interface check:
  - `ke_round_num` steps 0→14 with `ke_enable_round`=1 only during ROUND.
  - `ke_key` is constant throughout the block.

Source files
------------

// File: rtl/aes256_cipher_core_if.sv
// Plaintext/key input and ciphertext output handshakes of aes256_cipher_core.
// master drives offers and out_ready; slave is the cipher core.
interface aes256_cipher_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [255:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext
    );
endinterface

// File: rtl/aes256_cipher_core.sv
// Iterative AES-256 encryption, one round per cycle, fed by keyExpansion.
// Define AES_CIPHER_BACKTOBACK_EN to accept a new block on the retire edge.

module sbox (
    input  logic [7:0] a,
    output logic [7:0] c
);
    function automatic logic [7:0] gmul(input logic [7:0] x,
                                        input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xa;
        p  = 8'h00;
        xa = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ xa;
            xa = {xa[6:0], 1'b0} ^ (xa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] inv;

    assign inv = ginv(a);
    assign c   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes256_cipher_core (
    input  logic                       clk,
    input  logic                       reset,
    aes256_cipher_core_if.slave        bus,
    output logic [255:0]               ke_key,
    output logic [3:0]                 ke_round_num,
    output logic                       ke_enable_round,
    input  logic [127:0]               ke_round_key
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    state_e       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] st_q, st_d;
    logic [127:0] ct_q, ct_d;
    logic [255:0] key_q, key_d;
    logic [127:0] sb, sr, mc;
    logic         in_rdy;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        sbox u_sbox (
            .a (st_q[127-8*i -: 8]),
            .c (sb[127-8*i -: 8])
        );
    end

    // byte index is 4*col+row; row r rotates left by r columns
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
        end
    end

    always_comb begin
        state_d         = state_q;
        rnd_d           = rnd_q;
        pt_d            = pt_q;
        key_d           = key_q;
        st_d            = st_q;
        ct_d            = ct_q;
        in_rdy          = 1'b0;
        bus.out_valid   = 1'b0;
        ke_enable_round = 1'b0;
        ke_round_num    = 4'd0;
        unique case (state_q)
            IDLE: in_rdy = 1'b1;
            ROUND: begin
                ke_enable_round = 1'b1;
                ke_round_num    = rnd_q;
                rnd_d           = rnd_q + 4'd1;
                unique case (1'b1)
                    (rnd_q == 4'd0): st_d = pt_q ^ ke_round_key;
                    (rnd_q == 4'd14): begin
                        st_d    = sr ^ ke_round_key;
                        ct_d    = sr ^ ke_round_key;
                        rnd_d   = 4'd0;
                        state_d = DONE;
                    end
                    default: st_d = mc ^ ke_round_key;
                endcase
            end
            DONE: begin
                bus.out_valid = 1'b1;
`ifdef AES_CIPHER_BACKTOBACK_EN
                in_rdy = bus.out_ready;
`else
                in_rdy = 1'b0;
`endif
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.in_valid && in_rdy) begin
            pt_d    = bus.plaintext;
            key_d   = bus.key;
            rnd_d   = 4'd0;
            state_d = ROUND;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            pt_q    <= '0;
            key_q   <= '0;
            st_q    <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
            st_q    <= st_d;
            ct_q    <= ct_d;
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.ciphertext = ct_q;
    assign ke_key         = key_q;
endmodule

// File: tb/tb_aes256_cipher_core.sv
// Randomized bench for aes256_cipher_core with a keyExpansion stand-in
// and a byte-array AES-256 reference model.
module tb_aes256_cipher_core;
    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] ke_key;
    logic [3:0]   ke_round_num;
    logic         ke_enable_round;
    logic [127:0] ke_round_key;

    aes256_cipher_core_if bus ();

    aes256_cipher_core dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .ke_key          (ke_key),
        .ke_round_num    (ke_round_num),
        .ke_enable_round (ke_enable_round),
        .ke_round_key    (ke_round_key)
    );

    always #5 clk = ~clk;

`ifdef AES_CIPHER_BACKTOBACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    localparam logic [255:0] K_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C3 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_Z  = 128'hdc95c078a2408989ad48a21492842087;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] sbt [256];
    bit tab_ok = 1'b0;
    logic [1919:0] ke_all;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // schoolbook polynomial product, then reduce by 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc;
        logic [1919:0] res;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int i = 0; i < 60; i++) res[1919-32*i -: 32] = w[i];
        return res;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] k);
        logic [1919:0] rk;
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] res;
        rk = expand(k);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[1919-8*i -: 8];
        for (int r = 1; r < 15; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
            if (r < 14) begin
                for (int c = 0; c < 4; c++) begin
                    for (int w = 0; w < 4; w++) t[w] = s[4*c+w];
                    for (int w = 0; w < 4; w++)
                        s[4*c+w] = gmul(t[w], 8'h02) ^ gmul(t[(w+1)%4], 8'h03)
                                 ^ t[(w+2)%4] ^ t[(w+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[1919-128*r-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // keyExpansion stand-in: combinational round key for ke_round_num
    always @(ke_key or ke_round_num or tab_ok) begin
        ke_all = expand(ke_key);
        if (int'(ke_round_num) <= 14)
            ke_round_key = ke_all[1919-128*int'(ke_round_num) -: 128];
        else
            ke_round_key = '0;
    end

    // timing model: 15 edges from accept to result, one block at a time
    bit m_busy, m_ov, m_acc, m_ret;
    int m_cnt;
    logic [127:0] m_ct, m_pend;
    logic [255:0] m_key;

    function automatic bit exp_in_ready();
        return (!m_busy && !m_ov) || (B2B && m_ov && bus.out_ready);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0;
            m_ov   = 1'b0;
            m_cnt  = 0;
            m_ct   = '0;
            m_key  = '0;
        end else begin
            m_acc = bus.in_valid && exp_in_ready();
            m_ret = m_ov && bus.out_ready;
            if (m_ret) m_ov = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    m_ov   = 1'b1;
                    m_ct   = m_pend;
                end
            end
            if (m_acc) begin
                m_busy = 1'b1;
                m_cnt  = 15;
                m_pend = aes_ref(bus.plaintext, bus.key);
                m_key  = bus.key;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", bus.in_ready, exp_in_ready());
        chk("out_valid", bus.out_valid, m_ov);
        chk("ciphertext", bus.ciphertext, m_ct);
        chk("ke_enable_round", ke_enable_round, m_busy);
        chk("ke_round_num", ke_round_num, m_busy ? 15 - m_cnt : 0);
        chk("ke_key", ke_key, m_key);
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [127:0] pt, input logic [255:0] k);
        bit ok, rdy;
        ok = 1'b0;
        bus.in_valid  = 1'b1;
        bus.plaintext = pt;
        bus.key       = k;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            ok = rdy;
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.plaintext = rnd128();
        bus.key       = {rnd128(), rnd128()};
        if (!ok) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t1, t2, rises;
        bit prev;
        logic [127:0] held;
        logic [7:0] c63, inv, s;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.plaintext = '0;
        bus.key = '0;
        c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
                     ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
            sbt[x] = s;
        end
        tab_ok = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        idle(2);

        chk("ref_c3", aes_ref(PT_C3, K_C3), CT_C3);
        chk("ref_zero", aes_ref('0, '0), CT_Z);

        send(PT_C3, K_C3);
        wait_out(lat);
        chk("c3_latency", lat, 15);
        chk("c3_ct", bus.ciphertext, CT_C3);
        idle(2);

        send('0, '0);
        wait_out(lat);
        chk("zero_ct", bus.ciphertext, CT_Z);
        idle(2);

        bus.out_ready = 1'b0;
        send(rnd128(), {rnd128(), rnd128()});
        wait_out(lat);
        held = bus.ciphertext;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid  = 1'b1;
            bus.plaintext = rnd128();
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_ct_hold", bus.ciphertext, held);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        idle(3);

        send(PT_C3, K_C3);
        for (int i = 0; i < 40 && ke_round_num != 4'd7; i++) @(negedge clk);
        chk("rst_reach_rnd7", ke_round_num, 4'd7);
        #2 reset = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_ct", bus.ciphertext, 128'h0);
        chk("rst_ke_en", ke_enable_round, 1'b0);
        chk("rst_ke_rnd", ke_round_num, 4'd0);
        chk("rst_ke_key", ke_key, 256'h0);
        @(negedge clk);
        #2 reset = 1'b1;
        idle(2);
        send(PT_C3, K_C3);
        wait_out(lat);
        chk("post_rst_c3", bus.ciphertext, CT_C3);
        idle(2);

        bus.plaintext = PT_C3;
        bus.key = K_C3;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        prev = 1'b0;
        rises = 0;
        t1 = 0;
        t2 = 0;
        for (int i = 0; i < 80 && rises < 2; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid && !prev) begin
                rises++;
                if (rises == 1) t1 = cyc;
                else t2 = cyc;
            end
            prev = bus.out_valid;
        end
        bus.in_valid = 1'b0;
        chk("b2b_rises", rises, 2);
        chk("b2b_spacing", t2 - t1, B2B ? 16 : 17);
        idle(20);

        for (int i = 0; i < 1500; i++) begin
            bus.in_valid = ($urandom % 3 == 0);
            bus.plaintext = rnd128();
            bus.key = {rnd128(), rnd128()};
            bus.out_ready = ($urandom % 4 != 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
